// File: rtl/irda_tx_mux_guarded.sv
`default_nettype none
// ============================================================================
//  Module      : irda_tx_mux_guarded
//  Description : Registered IrDA transmit-output multiplexer. Selects one of
//                NCH encoder outputs, optionally ORs in the SIP pulse
//                generator, and holds the pad idle for GUARD_CYC cycles
//                whenever transmission starts or the selected mode changes.
//
//  Parameters  : NCH       - number of encoder channels (2..16)
//                SEL_W     - mode select width, 2**SEL_W >= NCH
//                GUARD_CYC - pad-idle guard length in clk cycles (>= 1)
//
//  Ports       : clk           core clock, rising edge
//                wb_rst_n      asynchronous active-low reset
//                enc_i         encoder outputs, bit k = channel k
//                sip_gen_i     SIP pulse generator output
//                sip_mask_i    bit k = 1 ORs sip_gen_i into channel k
//                tx_select_i   transmit enable
//                mode_sel_i    requested channel index
//                tx_invert_i   pad inversion (IRDA_TX_INVERT_EN builds only)
//                tx_pad_o      registered pad output
//                guard_o       high while the guard interval runs
//                active_sel_o  channel currently latched
//
//  Build macro : IRDA_TX_INVERT_EN - adds tx_invert_i; pad register loads
//                its next value XOR tx_invert_i in every state.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module irda_tx_mux_guarded #(
    parameter int NCH       = 4,
    parameter int SEL_W     = 2,
    parameter int GUARD_CYC = 16
) (
    input  logic             clk,
    input  logic             wb_rst_n,
    input  logic [NCH-1:0]   enc_i,
    input  logic             sip_gen_i,
    input  logic [NCH-1:0]   sip_mask_i,
    input  logic             tx_select_i,
    input  logic [SEL_W-1:0] mode_sel_i,
`ifdef IRDA_TX_INVERT_EN
    input  logic             tx_invert_i,
`endif
    output logic             tx_pad_o,
    output logic             guard_o,
    output logic [SEL_W-1:0] active_sel_o
);

    localparam int                c_cnt_w      = $clog2(GUARD_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_guard_load = c_cnt_w'(GUARD_CYC - 1);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_GUARD = 2'd1,
        S_ON    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]   active_sel_q, active_sel_d;
    logic               pad_q, pad_d;
    logic               guard_q, guard_d;

    logic               w_chan_bit;
    logic               w_mode_chg;
    logic               w_pad_base;

    // Channel mux. An index at or beyond NCH matches no channel, so the
    // selected value stays 0 and the pad remains idle.
    always_comb begin
        w_chan_bit = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (active_sel_q == SEL_W'(k)) begin
                w_chan_bit = enc_i[k] | (sip_gen_i & sip_mask_i[k]);
            end
        end
    end

    assign w_mode_chg = (mode_sel_i != active_sel_q);

    // Next state. Priority inside GUARD/ON: disable, then mode change,
    // then guard expiry.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        active_sel_d = active_sel_q;

        case (state_q)
            S_OFF: begin
                if (tx_select_i) begin
                    state_d      = S_GUARD;
                    active_sel_d = mode_sel_i;
                    cnt_d        = c_guard_load;
                end
            end
            S_GUARD: begin
                if (!tx_select_i) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end else if (w_mode_chg) begin
                    active_sel_d = mode_sel_i;
                    cnt_d        = c_guard_load;
                end else if (cnt_q == '0) begin
                    state_d = S_ON;
                end else begin
                    cnt_d = cnt_q - c_cnt_w'(1);
                end
            end
            S_ON: begin
                if (!tx_select_i) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end else if (w_mode_chg) begin
                    state_d      = S_GUARD;
                    active_sel_d = mode_sel_i;
                    cnt_d        = c_guard_load;
                end
            end
            default: begin
                state_d = S_OFF;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from the next state, so the pad carries
        // data from the very edge that enters ON and is idle from the edge
        // that leaves it. active_sel_q equals active_sel_d whenever the
        // next state is ON.
        w_pad_base = (state_d == S_ON) ? w_chan_bit : 1'b0;
`ifdef IRDA_TX_INVERT_EN
        pad_d      = w_pad_base ^ tx_invert_i;
`else
        pad_d      = w_pad_base;
`endif
        guard_d    = (state_d == S_GUARD);
    end

    always_ff @(posedge clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q      <= S_OFF;
            cnt_q        <= '0;
            active_sel_q <= '0;
            pad_q        <= 1'b0;
            guard_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            active_sel_q <= active_sel_d;
            pad_q        <= pad_d;
            guard_q      <= guard_d;
        end
    end

    assign tx_pad_o     = pad_q;
    assign guard_o      = guard_q;
    assign active_sel_o = active_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_irda_tx_mux_guarded.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irda_tx_mux_guarded
//  Description : Directed bench for irda_tx_mux_guarded. Instance A uses
//                NCH=4/GUARD_CYC=16, instance B uses NCH=3/GUARD_CYC=3 to
//                exercise an out-of-range select. The driver pushes the
//                expected registered outputs after each edge; a monitor on
//                the falling edge pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irda_tx_mux_guarded;

    typedef struct packed {
        logic       b;
        logic       pad;
        logic       grd;
        logic [1:0] sel;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       sip;
    // instance A
    logic [3:0] enc;
    logic [3:0] mask;
    logic       tx;
    logic [1:0] msel;
    logic       a_pad, a_grd;
    logic [1:0] a_sel;
    // instance B
    logic [2:0] b_enc;
    logic [2:0] b_mask;
    logic       b_tx;
    logic [1:0] b_msel;
    logic       b_pad, b_grd;
    logic [1:0] b_sel;
`ifdef IRDA_TX_INVERT_EN
    logic       inv;
`endif

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    logic e;

    irda_tx_mux_guarded #(.NCH(4), .SEL_W(2), .GUARD_CYC(16)) u_dut_a (
        .clk          (clk),
        .wb_rst_n     (rst_n),
        .enc_i        (enc),
        .sip_gen_i    (sip),
        .sip_mask_i   (mask),
        .tx_select_i  (tx),
        .mode_sel_i   (msel),
`ifdef IRDA_TX_INVERT_EN
        .tx_invert_i  (inv),
`endif
        .tx_pad_o     (a_pad),
        .guard_o      (a_grd),
        .active_sel_o (a_sel)
    );

    irda_tx_mux_guarded #(.NCH(3), .SEL_W(2), .GUARD_CYC(3)) u_dut_b (
        .clk          (clk),
        .wb_rst_n     (rst_n),
        .enc_i        (b_enc),
        .sip_gen_i    (sip),
        .sip_mask_i   (b_mask),
        .tx_select_i  (b_tx),
        .mode_sel_i   (b_msel),
`ifdef IRDA_TX_INVERT_EN
        .tx_invert_i  (1'b0),
`endif
        .tx_pad_o     (b_pad),
        .guard_o      (b_grd),
        .active_sel_o (b_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock edge; the expectation describes the outputs after it.
    task automatic cyc(input logic pad, input logic grd, input logic [1:0] sel,
                       input logic b = 1'b0);
        exp_t x;
        @(posedge clk);
        x.b = b; x.pad = pad; x.grd = grd; x.sel = sel;
        q.push_back(x);
        #1;
    endtask

    // Monitor: compares registered outputs mid-cycle.
    always @(negedge clk) begin
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            if (x.b) begin
                check("b_pad",   int'(b_pad), int'(x.pad));
                check("b_guard", int'(b_grd), int'(x.grd));
                check("b_sel",   int'(b_sel), int'(x.sel));
            end else begin
                check("pad",   int'(a_pad), int'(x.pad));
                check("guard", int'(a_grd), int'(x.grd));
                check("sel",   int'(a_sel), int'(x.sel));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; sip = 1'b0;
        enc = '0; mask = '0; tx = 1'b0; msel = '0;
        b_enc = '0; b_mask = '0; b_tx = 1'b0; b_msel = '0;
`ifdef IRDA_TX_INVERT_EN
        inv = 1'b0;
`endif
        // reset state
        repeat (2) cyc(0, 0, 0);
        rst_n = 1'b1;
        repeat (2) cyc(0, 0, 0);

        // enable with sel=1, enc[1] toggling every cycle
        tx = 1'b1; msel = 2'd1; e = 1'b0;
        for (int i = 0; i < 16; i++) begin
            enc = 4'b0000; enc[1] = e; cyc(0, 1, 1); e = ~e;
        end
        for (int i = 0; i < 6; i++) begin
            enc = 4'b0000; enc[1] = e; cyc(e, 0, 1); e = ~e;
        end

        // mode switch 1 -> 3
        msel = 2'd3;
        for (int i = 0; i < 16; i++) begin
            enc = 4'b0000; enc[3] = e; cyc(0, 1, 3); e = ~e;
        end
        for (int i = 0; i < 4; i++) begin
            enc = 4'b0000; enc[3] = e; cyc(e, 0, 3); e = ~e;
        end

        // switch to 0, then to 2 at guard cycle 10: guard restarts
        msel = 2'd0;
        repeat (10) cyc(0, 1, 0);
        msel = 2'd2;
        repeat (16) cyc(0, 1, 2);

        // SIP OR into channel 2
        enc = 4'b0000; mask = 4'b0100; sip = 1'b1;
        repeat (3) cyc(1, 0, 2);
        sip = 1'b0;
        repeat (2) cyc(0, 0, 2);
        mask = 4'b0000; sip = 1'b1;
        repeat (3) cyc(0, 0, 2);
        sip = 1'b0;
        enc = 4'b0100; cyc(1, 0, 2);
        enc = 4'b1011; cyc(0, 0, 2);

        // disable together with a mode change: disable wins, sel kept
        tx = 1'b0; msel = 2'd1;
        cyc(0, 0, 2); cyc(0, 0, 2);

        // abort guard early, then re-enable: full guard again
        tx = 1'b1;
        repeat (5) cyc(0, 1, 1);
        tx = 1'b0; cyc(0, 0, 1);
        tx = 1'b1;
        repeat (16) cyc(0, 1, 1);
        // mode change on the expiry edge beats expiry
        msel = 2'd0; enc = 4'b0000;
        repeat (16) cyc(0, 1, 0);
        enc = 4'b0001; cyc(1, 0, 0);
        enc = 4'b0000; cyc(0, 0, 0);

        // reach ON with sel=2, enc=0100, then reset asynchronously
        msel = 2'd2;
        repeat (16) cyc(0, 1, 2);
        enc = 4'b0100;
        cyc(1, 0, 2); cyc(1, 0, 2);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_pad",   int'(a_pad), 0);
        check("async_rst_guard", int'(a_grd), 0);
        check("async_rst_sel",   int'(a_sel), 0);
        tx = 1'b0; msel = 2'd0; enc = 4'b0000;
        cyc(0, 0, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0);

        // instance B: NCH=3, select 3 is out of range
        b_tx = 1'b1; b_msel = 2'd3; b_enc = 3'b111; b_mask = 3'b111; sip = 1'b1;
        repeat (3) cyc(0, 1, 3, 1'b1);
        repeat (4) cyc(0, 0, 3, 1'b1);
        b_msel = 2'd2;
        repeat (3) cyc(0, 1, 2, 1'b1);
        cyc(1, 0, 2, 1'b1);
        b_tx = 1'b0; sip = 1'b0;
        cyc(0, 0, 2, 1'b1);

`ifdef IRDA_TX_INVERT_EN
        // inverted idle level in OFF, inverted data in ON
        inv = 1'b1;
        cyc(1, 0, 0);
        tx = 1'b1; msel = 2'd1;
        repeat (16) cyc(1, 1, 1);
        enc = 4'b0010; cyc(0, 0, 1);
        enc = 4'b0000; cyc(1, 0, 1);
        tx = 1'b0; inv = 1'b0;
        cyc(0, 0, 1);
`endif

        @(negedge clk); #1;
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
